// File: rtl/game_sequencer.sv
// Play controller: owns the board and piece registers, arbitrates buttons against
// the gravity timer, and sequences one move_piece or drop operation at a time.
module game_sequencer #(
  parameter int unsigned DROP_PERIOD = 16,
  parameter int unsigned GW          = 8,
  parameter logic [4:0]  SPAWN_LOC   = 5'd1
) (
  input  logic        clka,
  input  logic        reset,
  input  logic        game_start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rotate,
  output logic        mp_start,
  output logic        mp_left,
  output logic        mp_right,
  output logic        mp_rotate,
  input  logic        mp_done,
  input  logic [4:0]  mp_new_location,
  input  logic [1:0]  mp_new_rotation,
  input  logic [31:0] mp_new_board_state,
  output logic        dr_start,
  input  logic        dr_done,
  input  logic        dr_landed,
  input  logic [4:0]  dr_new_location,
  input  logic [31:0] dr_new_board_state,
  output logic [31:0] board_state,
  output logic [1:0]  piece_type,
  output logic [4:0]  piece_location,
  output logic [1:0]  piece_rotation,
  output logic        busy,
  output logic        game_over,
  output logic [7:0]  pieces_placed
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_WAIT_CMD,
    S_MOVE_REQ,
    S_MOVE_WAIT,
    S_DROP_REQ,
    S_DROP_WAIT,
    S_GAME_OVER
  } state_e;

  localparam logic [GW-1:0] GRAV_LAST = GW'(DROP_PERIOD - 1);

  state_e        state_q, state_d;
  logic [31:0]   board_q, board_d;
  logic [1:0]    type_q, type_d;
  logic [1:0]    type_cnt_q, type_cnt_d;
  logic [4:0]    loc_q, loc_d;
  logic [1:0]    rot_q, rot_d;
  logic [7:0]    placed_q, placed_d;
  logic [GW-1:0] grav_cnt_q, grav_cnt_d;
  logic          pend_left_q, pend_left_d;
  logic          pend_right_q, pend_right_d;
  logic          pend_rot_q, pend_rot_d;
  logic          pend_grav_q, pend_grav_d;
  logic          left_prev_q, left_prev_d;
  logic          right_prev_q, right_prev_d;
  logic          rot_prev_q, rot_prev_d;
  // {rotate, right, left}; held from MOVE_REQ until mp_done
  logic [2:0]    cmd_q, cmd_d;

  logic active;

  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    type_d       = type_q;
    type_cnt_d   = type_cnt_q;
    loc_d        = loc_q;
    rot_d        = rot_q;
    placed_d     = placed_q;
    grav_cnt_d   = grav_cnt_q;
    cmd_d        = cmd_q;
    left_prev_d  = btn_left;
    right_prev_d = btn_right;
    rot_prev_d   = btn_rotate;

    active = (state_q != S_IDLE) && (state_q != S_GAME_OVER);

    pend_left_d  = 1'b0;
    pend_right_d = 1'b0;
    pend_rot_d   = 1'b0;
    pend_grav_d  = 1'b0;
    if (active) begin
      pend_left_d  = pend_left_q  | (btn_left   & ~left_prev_q);
      pend_right_d = pend_right_q | (btn_right  & ~right_prev_q);
      pend_rot_d   = pend_rot_q   | (btn_rotate & ~rot_prev_q);
      pend_grav_d  = pend_grav_q;
      if (grav_cnt_q == GRAV_LAST) begin
        grav_cnt_d  = '0;
        pend_grav_d = 1'b1;
      end else begin
        grav_cnt_d = grav_cnt_q + GW'(1);
      end
    end

    // State actions below run after flag capture so that a service clear wins.
    unique case (state_q)
      S_IDLE: begin
        if (game_start) state_d = S_SPAWN;
      end
      S_SPAWN: begin
        if (board_q[SPAWN_LOC]) begin
          state_d = S_GAME_OVER;
        end else begin
          board_d     = board_q | (32'd1 << SPAWN_LOC);
          loc_d       = SPAWN_LOC;
          rot_d       = '0;
          type_d      = type_cnt_q;
          type_cnt_d  = type_cnt_q + 2'd1;
          grav_cnt_d  = '0;
          pend_grav_d = 1'b0;
          state_d     = S_WAIT_CMD;
        end
      end
      S_WAIT_CMD: begin
        if (pend_grav_q) begin
          pend_grav_d = 1'b0;
          state_d     = S_DROP_REQ;
        end else if (pend_rot_q) begin
          pend_rot_d = 1'b0;
          cmd_d      = 3'b100;
          state_d    = S_MOVE_REQ;
        end else if (pend_left_q && pend_right_q) begin
          pend_left_d  = 1'b0;
          pend_right_d = 1'b0;
        end else if (pend_left_q) begin
          pend_left_d = 1'b0;
          cmd_d       = 3'b001;
          state_d     = S_MOVE_REQ;
        end else if (pend_right_q) begin
          pend_right_d = 1'b0;
          cmd_d        = 3'b010;
          state_d      = S_MOVE_REQ;
        end
      end
      S_MOVE_REQ: state_d = S_MOVE_WAIT;
      S_MOVE_WAIT: begin
        if (mp_done) begin
          loc_d   = mp_new_location;
          rot_d   = mp_new_rotation;
          board_d = mp_new_board_state;
          cmd_d   = '0;
          state_d = S_WAIT_CMD;
        end
      end
      S_DROP_REQ: state_d = S_DROP_WAIT;
      S_DROP_WAIT: begin
        if (dr_done) begin
          loc_d   = dr_new_location;
          board_d = dr_new_board_state;
          if (dr_landed) begin
            if (placed_q != 8'hFF) placed_d = placed_q + 8'd1;
            state_d = S_SPAWN;
          end else begin
            state_d = S_WAIT_CMD;
          end
        end
      end
      S_GAME_OVER: begin
        if (game_start) begin
          board_d  = '0;
          placed_d = '0;
          state_d  = S_SPAWN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      state_q      <= S_IDLE;
      board_q      <= '0;
      type_q       <= '0;
      type_cnt_q   <= '0;
      loc_q        <= '0;
      rot_q        <= '0;
      placed_q     <= '0;
      grav_cnt_q   <= '0;
      pend_left_q  <= 1'b0;
      pend_right_q <= 1'b0;
      pend_rot_q   <= 1'b0;
      pend_grav_q  <= 1'b0;
      left_prev_q  <= 1'b0;
      right_prev_q <= 1'b0;
      rot_prev_q   <= 1'b0;
      cmd_q        <= '0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      type_q       <= type_d;
      type_cnt_q   <= type_cnt_d;
      loc_q        <= loc_d;
      rot_q        <= rot_d;
      placed_q     <= placed_d;
      grav_cnt_q   <= grav_cnt_d;
      pend_left_q  <= pend_left_d;
      pend_right_q <= pend_right_d;
      pend_rot_q   <= pend_rot_d;
      pend_grav_q  <= pend_grav_d;
      left_prev_q  <= left_prev_d;
      right_prev_q <= right_prev_d;
      rot_prev_q   <= rot_prev_d;
      cmd_q        <= cmd_d;
    end
  end

  assign mp_start       = (state_q == S_MOVE_REQ);
  assign dr_start       = (state_q == S_DROP_REQ);
  assign mp_left        = cmd_q[0];
  assign mp_right       = cmd_q[1];
  assign mp_rotate      = cmd_q[2];
  assign busy           = (state_q == S_MOVE_REQ) || (state_q == S_MOVE_WAIT) ||
                          (state_q == S_DROP_REQ) || (state_q == S_DROP_WAIT);
  assign game_over      = (state_q == S_GAME_OVER);
  assign board_state    = board_q;
  assign piece_type     = type_q;
  assign piece_location = loc_q;
  assign piece_rotation = rot_q;
  assign pieces_placed  = placed_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench: u_dut (gravity period 40) covers buttons and arbitration,
// u_fast (gravity period 4) covers drops, landing, game over and reset abort.
module tb_game_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, game_start, btn_left, btn_right, btn_rotate;
  logic        mp_done;
  logic [4:0]  mp_new_location;
  logic [1:0]  mp_new_rotation;
  logic [31:0] mp_new_board_state;
  logic        dr_done, dr_landed;
  logic [4:0]  dr_new_location;
  logic [31:0] dr_new_board_state;

  logic        mp_start, mp_left, mp_right, mp_rotate, dr_start, busy, game_over;
  logic [31:0] board_state;
  logic [1:0]  piece_type, piece_rotation;
  logic [4:0]  piece_location;
  logic [7:0]  pieces_placed;

  logic        f_dr_done, f_dr_landed;
  logic [4:0]  f_dr_new_location;
  logic [31:0] f_dr_new_board_state;
  logic        f_mp_start, f_mp_left, f_mp_right, f_mp_rotate, f_dr_start, f_busy, f_game_over;
  logic [31:0] f_board_state;
  logic [1:0]  f_piece_type, f_piece_rotation;
  logic [4:0]  f_piece_location;
  logic [7:0]  f_pieces_placed;

  int vec_count  = 0;
  int miscompares = 0;

  game_sequencer #(.DROP_PERIOD(40)) u_dut (
    .clka(clk), .reset(reset), .game_start(game_start),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rotate(btn_rotate),
    .mp_start(mp_start), .mp_left(mp_left), .mp_right(mp_right), .mp_rotate(mp_rotate),
    .mp_done(mp_done), .mp_new_location(mp_new_location),
    .mp_new_rotation(mp_new_rotation), .mp_new_board_state(mp_new_board_state),
    .dr_start(dr_start), .dr_done(dr_done), .dr_landed(dr_landed),
    .dr_new_location(dr_new_location), .dr_new_board_state(dr_new_board_state),
    .board_state(board_state), .piece_type(piece_type), .piece_location(piece_location),
    .piece_rotation(piece_rotation), .busy(busy), .game_over(game_over),
    .pieces_placed(pieces_placed)
  );

  game_sequencer #(.DROP_PERIOD(4)) u_fast (
    .clka(clk), .reset(reset), .game_start(game_start),
    .btn_left(1'b0), .btn_right(1'b0), .btn_rotate(1'b0),
    .mp_start(f_mp_start), .mp_left(f_mp_left), .mp_right(f_mp_right), .mp_rotate(f_mp_rotate),
    .mp_done(1'b0), .mp_new_location(5'd0),
    .mp_new_rotation(2'd0), .mp_new_board_state(32'd0),
    .dr_start(f_dr_start), .dr_done(f_dr_done), .dr_landed(f_dr_landed),
    .dr_new_location(f_dr_new_location), .dr_new_board_state(f_dr_new_board_state),
    .board_state(f_board_state), .piece_type(f_piece_type), .piece_location(f_piece_location),
    .piece_rotation(f_piece_rotation), .busy(f_busy), .game_over(f_game_over),
    .pieces_placed(f_pieces_placed)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves both DUTs in the first WAIT_CMD cycle after a fresh spawn (gravity count 0).
  task automatic start_play;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1; game_start = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_rotate = 1'b0;
    mp_done = 1'b0; mp_new_location = '0; mp_new_rotation = '0; mp_new_board_state = '0;
    dr_done = 1'b0; dr_landed = 1'b0; dr_new_location = '0; dr_new_board_state = '0;
    f_dr_done = 1'b0; f_dr_landed = 1'b0; f_dr_new_location = '0; f_dr_new_board_state = '0;
    tick();
    tick();
    vec_count++;
    if ({mp_start, mp_left, mp_right, mp_rotate, dr_start, busy, game_over} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b want 0000000", {mp_start, mp_left, mp_right, mp_rotate, dr_start, busy, game_over});
    end
    vec_count++;
    if ({board_state, piece_type, piece_location, piece_rotation, pieces_placed} !== 49'd0) begin
      miscompares++;
      $display("FAIL reset_regs: got %h want 0", {board_state, piece_type, piece_location, piece_rotation, pieces_placed});
    end
    vec_count++;
    if ({f_mp_start, f_dr_start, f_busy, f_game_over, f_board_state, f_pieces_placed} !== 44'd0) begin
      miscompares++;
      $display("FAIL reset_fast: got %h want 0", {f_mp_start, f_dr_start, f_busy, f_game_over, f_board_state, f_pieces_placed});
    end
  endtask

  task automatic test_spawn;
    start_play();
    vec_count++;
    if ({piece_type, piece_location, piece_rotation} !== {2'd0, 5'd1, 2'd0}) begin
      miscompares++;
      $display("FAIL spawn_piece: got %h want %h", {piece_type, piece_location, piece_rotation}, {2'd0, 5'd1, 2'd0});
    end
    vec_count++;
    if (board_state !== 32'h0000_0002) begin
      miscompares++;
      $display("FAIL spawn_board: got %h want 00000002", board_state);
    end
    vec_count++;
    if ({busy, game_over, mp_start, dr_start} !== 4'b0) begin
      miscompares++;
      $display("FAIL spawn_ctl: got %b want 0000", {busy, game_over, mp_start, dr_start});
    end
  endtask

  task automatic test_rotate;
    start_play();
    btn_rotate = 1'b1;           // c0
    tick();                      // c1: flag pending
    btn_rotate = 1'b0;
    vec_count++;
    if (mp_start !== 1'b0) begin
      miscompares++;
      $display("FAIL rot_early: got mp_start=%b want 0", mp_start);
    end
    tick();                      // c2: MOVE_REQ
    vec_count++;
    if ({mp_start, mp_left, mp_right, mp_rotate, busy} !== 5'b10011) begin
      miscompares++;
      $display("FAIL rot_req: got %b want 10011", {mp_start, mp_left, mp_right, mp_rotate, busy});
    end
    tick();                      // c3: MOVE_WAIT
    vec_count++;
    if ({mp_start, mp_rotate, busy} !== 3'b011) begin
      miscompares++;
      $display("FAIL rot_hold: got %b want 011", {mp_start, mp_rotate, busy});
    end
    mp_done = 1'b1; mp_new_location = 5'd6; mp_new_rotation = 2'd1; mp_new_board_state = 32'hD000_0040;
    tick();                      // c4: WAIT_CMD
    mp_done = 1'b0;
    vec_count++;
    if ({piece_location, piece_rotation, board_state} !== {5'd6, 2'd1, 32'hD000_0040}) begin
      miscompares++;
      $display("FAIL rot_result: got %h want %h", {piece_location, piece_rotation, board_state}, {5'd6, 2'd1, 32'hD000_0040});
    end
    vec_count++;
    if ({busy, mp_rotate, mp_start} !== 3'b000) begin
      miscompares++;
      $display("FAIL rot_idle: got %b want 000", {busy, mp_rotate, mp_start});
    end
  endtask

  task automatic test_left_right;
    start_play();
    btn_left = 1'b1; btn_right = 1'b1;   // c0
    tick();                              // c1: both pending
    btn_left = 1'b0; btn_right = 1'b0;
    tick();                              // c2: both cleared
    vec_count++;
    if ({mp_start, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL lr_cancel: got %b want 00", {mp_start, busy});
    end
    mp_done = 1'b1; mp_new_location = 5'd20; mp_new_rotation = 2'd3; mp_new_board_state = 32'h0000_FFFF;
    tick();                              // c3: stray mp_done ignored
    mp_done = 1'b0;
    vec_count++;
    if ({piece_location, piece_rotation, board_state, mp_start} !== {5'd1, 2'd0, 32'h0000_0002, 1'b0}) begin
      miscompares++;
      $display("FAIL lr_stray_done: got %h want %h", {piece_location, piece_rotation, board_state, mp_start}, {5'd1, 2'd0, 32'h0000_0002, 1'b0});
    end
    btn_right = 1'b1;
    tick();                              // c4
    btn_right = 1'b0;
    tick();                              // c5: MOVE_REQ
    vec_count++;
    if ({mp_start, mp_left, mp_right, mp_rotate} !== 4'b1010) begin
      miscompares++;
      $display("FAIL lr_right: got %b want 1010", {mp_start, mp_left, mp_right, mp_rotate});
    end
    tick();                              // c6: MOVE_WAIT
    mp_done = 1'b1; mp_new_location = 5'd2; mp_new_rotation = 2'd0; mp_new_board_state = 32'h0000_0004;
    tick();                              // c7
    mp_done = 1'b0;
    vec_count++;
    if ({piece_location, board_state, busy, mp_right} !== {5'd2, 32'h0000_0004, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL lr_result: got %h want %h", {piece_location, board_state, busy, mp_right}, {5'd2, 32'h0000_0004, 1'b0, 1'b0});
    end
  endtask

  task automatic test_grav_during_move;
    start_play();
    btn_rotate = 1'b1;                   // c0
    tick();
    btn_rotate = 1'b0;
    tick();                              // c2: MOVE_REQ rotate
    tick();                              // c3: MOVE_WAIT, response withheld
    tick(); tick();                      // c5
    btn_left = 1'b1;
    tick();                              // c6: left pending while busy
    btn_left = 1'b0;
    repeat (35) tick();                  // c41: gravity pending since c40
    vec_count++;
    if ({busy, dr_start, mp_start} !== 3'b100) begin
      miscompares++;
      $display("FAIL gm_wait: got %b want 100", {busy, dr_start, mp_start});
    end
    mp_done = 1'b1; mp_new_location = 5'd3; mp_new_rotation = 2'd2; mp_new_board_state = 32'h0000_0008;
    tick();                              // c42: WAIT_CMD
    mp_done = 1'b0;
    vec_count++;
    if ({busy, dr_start, mp_start, piece_location, piece_rotation} !== {3'b000, 5'd3, 2'd2}) begin
      miscompares++;
      $display("FAIL gm_done: got %h want %h", {busy, dr_start, mp_start, piece_location, piece_rotation}, {3'b000, 5'd3, 2'd2});
    end
    tick();                              // c43: drop wins
    vec_count++;
    if ({dr_start, mp_start, mp_left} !== 3'b100) begin
      miscompares++;
      $display("FAIL gm_drop_first: got %b want 100", {dr_start, mp_start, mp_left});
    end
    tick();                              // c44: DROP_WAIT
    dr_done = 1'b1; dr_landed = 1'b0; dr_new_location = 5'd11; dr_new_board_state = 32'h0000_0800;
    tick();                              // c45
    dr_done = 1'b0;
    vec_count++;
    if ({piece_location, board_state, pieces_placed} !== {5'd11, 32'h0000_0800, 8'd0}) begin
      miscompares++;
      $display("FAIL gm_drop_res: got %h want %h", {piece_location, board_state, pieces_placed}, {5'd11, 32'h0000_0800, 8'd0});
    end
    tick();                              // c46: pending left serviced
    vec_count++;
    if ({mp_start, mp_left, mp_right, mp_rotate, dr_start} !== 5'b11000) begin
      miscompares++;
      $display("FAIL gm_left_after: got %b want 11000", {mp_start, mp_left, mp_right, mp_rotate, dr_start});
    end
  endtask

  task automatic test_gravity_land;
    start_play();
    repeat (4) tick();                   // c4
    vec_count++;
    if (f_dr_start !== 1'b0) begin
      miscompares++;
      $display("FAIL gl_tick1_early: got %b want 0", f_dr_start);
    end
    tick();                              // c5
    vec_count++;
    if ({f_dr_start, f_busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL gl_tick1: got %b want 11", {f_dr_start, f_busy});
    end
    tick();                              // c6: DROP_WAIT
    f_dr_done = 1'b1; f_dr_landed = 1'b0; f_dr_new_location = 5'd9; f_dr_new_board_state = 32'h0000_0200;
    tick();                              // c7
    f_dr_done = 1'b0;
    vec_count++;
    if ({f_piece_location, f_board_state, f_busy} !== {5'd9, 32'h0000_0200, 1'b0}) begin
      miscompares++;
      $display("FAIL gl_fall: got %h want %h", {f_piece_location, f_board_state, f_busy}, {5'd9, 32'h0000_0200, 1'b0});
    end
    tick();                              // c8
    vec_count++;
    if (f_dr_start !== 1'b0) begin
      miscompares++;
      $display("FAIL gl_tick2_early: got %b want 0", f_dr_start);
    end
    tick();                              // c9
    vec_count++;
    if (f_dr_start !== 1'b1) begin
      miscompares++;
      $display("FAIL gl_tick2: got %b want 1", f_dr_start);
    end
    tick();                              // c10
    f_dr_done = 1'b1; f_dr_landed = 1'b1; f_dr_new_location = 5'd9; f_dr_new_board_state = 32'h0000_0200;
    tick();                              // c11: SPAWN
    f_dr_done = 1'b0; f_dr_landed = 1'b0;
    vec_count++;
    if ({f_pieces_placed, f_busy} !== {8'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL gl_placed: got %h want %h", {f_pieces_placed, f_busy}, {8'd1, 1'b0});
    end
    tick();                              // c12: next piece
    vec_count++;
    if ({f_piece_type, f_piece_location, f_piece_rotation, f_board_state} !== {2'd1, 5'd1, 2'd0, 32'h0000_0202}) begin
      miscompares++;
      $display("FAIL gl_respawn: got %h want %h", {f_piece_type, f_piece_location, f_piece_rotation, f_board_state}, {2'd1, 5'd1, 2'd0, 32'h0000_0202});
    end
  endtask

  task automatic test_game_over;
    repeat (5) tick();                   // c17 after respawn
    vec_count++;
    if (f_dr_start !== 1'b1) begin
      miscompares++;
      $display("FAIL go_drop: got %b want 1", f_dr_start);
    end
    tick();                              // DROP_WAIT
    f_dr_done = 1'b1; f_dr_landed = 1'b1; f_dr_new_location = 5'd4; f_dr_new_board_state = 32'h0000_0012;
    tick();                              // SPAWN with spawn bit occupied
    f_dr_done = 1'b0; f_dr_landed = 1'b0;
    tick();                              // GAME_OVER
    vec_count++;
    if ({f_game_over, f_busy, f_board_state, f_pieces_placed, f_piece_type, f_piece_location} !==
        {1'b1, 1'b0, 32'h0000_0012, 8'd2, 2'd1, 5'd4}) begin
      miscompares++;
      $display("FAIL go_state: got %h want %h", {f_game_over, f_busy, f_board_state, f_pieces_placed, f_piece_type, f_piece_location},
               {1'b1, 1'b0, 32'h0000_0012, 8'd2, 2'd1, 5'd4});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      vec_count++;
      if ({f_mp_start, f_dr_start, f_game_over} !== 3'b001) begin
        miscompares++;
        $display("FAIL go_hold[%0d]: got %b want 001", i, {f_mp_start, f_dr_start, f_game_over});
      end
    end
    game_start = 1'b1;
    tick();                              // SPAWN on cleared board
    game_start = 1'b0;
    tick();
    vec_count++;
    if ({f_game_over, f_piece_type, f_piece_location, f_board_state, f_pieces_placed} !==
        {1'b0, 2'd2, 5'd1, 32'h0000_0002, 8'd0}) begin
      miscompares++;
      $display("FAIL go_restart: got %h want %h", {f_game_over, f_piece_type, f_piece_location, f_board_state, f_pieces_placed},
               {1'b0, 2'd2, 5'd1, 32'h0000_0002, 8'd0});
    end
  endtask

  task automatic test_reset_abort;
    repeat (5) tick();                   // DROP_REQ
    tick();                              // DROP_WAIT
    vec_count++;
    if ({f_busy, f_dr_start} !== 2'b10) begin
      miscompares++;
      $display("FAIL ra_wait: got %b want 10", {f_busy, f_dr_start});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    f_dr_done = 1'b1; f_dr_landed = 1'b1; f_dr_new_location = 5'd7; f_dr_new_board_state = 32'hFFFF_FFFF;
    tick();
    f_dr_done = 1'b0; f_dr_landed = 1'b0;
    vec_count++;
    if ({f_board_state, f_piece_type, f_piece_location, f_piece_rotation, f_pieces_placed} !== 49'd0) begin
      miscompares++;
      $display("FAIL ra_regs: got %h want 0", {f_board_state, f_piece_type, f_piece_location, f_piece_rotation, f_pieces_placed});
    end
    for (int i = 0; i < 8; i++) begin
      vec_count++;
      if ({f_mp_start, f_mp_left, f_mp_right, f_mp_rotate, f_dr_start, f_busy, f_game_over} !== 7'b0) begin
        miscompares++;
        $display("FAIL ra_idle[%0d]: got %b want 0000000", i, {f_mp_start, f_mp_left, f_mp_right, f_mp_rotate, f_dr_start, f_busy, f_game_over});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_rotate();
    test_left_right();
    test_grav_during_move();
    test_gravity_land();
    test_game_over();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
